// File: rtl/rpc2_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rpc2_ctrl_pkg
// Shared definitions for the RPC2 controller write/read address path:
//   - AXI burst encodings
//   - splitter FSM state type
//   - width derivation for the ip_len field and the packed ADR word
//   - bit positions of the fields inside the packed ADR word
//     {size[1:0], burst[1:0], ip_len[IP_LEN-1:0], addr[31:0]}
// -----------------------------------------------------------------------------
package rpc2_ctrl_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } split_state_t;

    // The ip_len field grows by one bit on the 64-bit data path.
    function automatic int ip_len_width(input int data_width);
        return (data_width == 64) ? 11 : 10;
    endfunction

    function automatic int pre_adr_width(input int data_width);
        return 32 + ip_len_width(data_width) + 4;
    endfunction

    localparam int ADR_ADDR_LSB = 0;
    localparam int ADR_ADDR_W   = 32;
    localparam int ADR_LEN_LSB  = 32;

    function automatic int adr_burst_lsb(input int ip_len);
        return 32 + ip_len;
    endfunction

    function automatic int adr_size_lsb(input int ip_len);
        return 34 + ip_len;
    endfunction

endpackage

// File: rtl/rpc2_ctrl_page_chunk_calc.sv
// -----------------------------------------------------------------------------
// rpc2_ctrl_page_chunk_calc
// Purely combinational page-chunk calculator shared by the read and write
// splitters. Given the current byte address and the number of IP units still
// to be issued, it returns the size of the next command such that the command
// never crosses a 2^C_BOUNDARY_BITS byte page (INCR bursts only), plus the
// address/remaining count after that command has been issued.
//
// Ports:
//   cur_addr      in  32        current command byte address (may be unaligned)
//   rem           in  IP_LEN+1  IP units still to issue (>= 1 while busy)
//   ip_data_size  in  2         log2 bytes per IP unit
//   burst         in  2         AXI burst type
//   len           out IP_LEN    units in this command minus 1
//   last          out 1         this command finishes the request
//   next_addr     out 32        address of the following command
//   next_rem      out IP_LEN+1  units left after this command
// -----------------------------------------------------------------------------
module rpc2_ctrl_page_chunk_calc
    import rpc2_ctrl_pkg::*;
#(
    parameter int IP_LEN          = 10,
    parameter int C_BOUNDARY_BITS = 10,
    parameter int C_SPLIT_EN      = 1
) (
    input  logic [31:0]     cur_addr,
    input  logic [IP_LEN:0] rem,
    input  logic [1:0]      ip_data_size,
    input  logic [1:0]      burst,
    output logic [IP_LEN-1:0] len,
    output logic            last,
    output logic [31:0]     next_addr,
    output logic [IP_LEN:0] next_rem
);

    logic [31:0]     unit_mask;
    logic [31:0]     ua;
    logic [31:0]     page_off;
    logic [31:0]     avail;
    logic [31:0]     rem_ext;
    logic [IP_LEN:0] chunk;
    logic [31:0]     chunk_ext;

    // The unit-aligned address is used for the page arithmetic so that an
    // unaligned first address still counts the unit it lives in. Because ua is
    // unit aligned and ip_data_size < C_BOUNDARY_BITS, avail is always >= 1,
    // so every command makes forward progress.
    always_comb begin
        unit_mask = ~((32'd1 << ip_data_size) - 32'd1);
        ua        = cur_addr & unit_mask;
        page_off  = ua & ((32'd1 << C_BOUNDARY_BITS) - 32'd1);
        avail     = ((32'd1 << C_BOUNDARY_BITS) - page_off) >> ip_data_size;
        rem_ext   = {{(31 - IP_LEN){1'b0}}, rem};

        if ((burst == BURST_INCR) && (C_SPLIT_EN != 0) && (avail < rem_ext)) begin
            chunk = avail[IP_LEN:0];
        end else begin
            chunk = rem;
        end

        chunk_ext = {{(31 - IP_LEN){1'b0}}, chunk};
        len       = chunk[IP_LEN-1:0] - {{(IP_LEN-1){1'b0}}, 1'b1};
        last      = (chunk == rem);
        next_addr = ua + (chunk_ext << ip_data_size);
        next_rem  = rem - chunk;
    end

endmodule

// File: rtl/rpc2_ctrl_adr_wr_splitter.sv
// -----------------------------------------------------------------------------
// rpc2_ctrl_adr_wr_splitter
// Splits INCR write-address requests into commands that never cross a
// 2^C_BOUNDARY_BITS byte page; FIXED/WRAP requests (or everything when
// C_SPLIT_EN=0) pass through as a single command. One request is in flight at
// a time; the request port reopens the cycle after the final command handshake.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   adr_aw_valid    in   request valid
//   adr_aw_ready    out  request accepted when valid & ready (high in IDLE)
//   adr_aw_din      in   {size, burst, ip_len, addr}
//   adr_aw_block    in   source block tag, copied to cmd_block
//   ip_data_size    in   log2 bytes per IP unit, sampled at accept
//   cmd_valid       out  command valid (held until cmd_ready)
//   cmd_ready       in   downstream accept
//   cmd_addr        out  command byte address
//   cmd_len         out  IP units minus 1
//   cmd_burst       out  burst type of the request
//   cmd_size        out  AXI size of the request
//   cmd_block       out  block tag of the request
//   cmd_last        out  final command of the request
// -----------------------------------------------------------------------------
module rpc2_ctrl_adr_wr_splitter
    import rpc2_ctrl_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH   = 32,
    parameter int C_BOUNDARY_BITS    = 10,
    parameter int C_SPLIT_EN         = 1,
    localparam int IP_LEN             = ip_len_width(C_AXI_DATA_WIDTH),
    localparam int PRE_ADR_DATA_WIDTH = pre_adr_width(C_AXI_DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          adr_aw_valid,
    output logic                          adr_aw_ready,
    input  logic [PRE_ADR_DATA_WIDTH-1:0] adr_aw_din,
    input  logic                          adr_aw_block,
    input  logic [1:0]                    ip_data_size,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [31:0]                   cmd_addr,
    output logic [IP_LEN-1:0]             cmd_len,
    output logic [1:0]                    cmd_burst,
    output logic [1:0]                    cmd_size,
    output logic                          cmd_block,
    output logic                          cmd_last
);

    localparam int BURST_LSB = adr_burst_lsb(IP_LEN);
    localparam int SIZE_LSB  = adr_size_lsb(IP_LEN);

    split_state_t state;
    split_state_t state_next;

    logic [31:0]       cur_addr;
    logic [IP_LEN:0]   rem;
    logic [1:0]        burst_q;
    logic [1:0]        size_q;
    logic              block_q;
    logic [1:0]        ds_q;

    logic              accept;
    logic              advance;

    logic [31:0]       din_addr;
    logic [IP_LEN-1:0] din_len;
    logic [1:0]        din_burst;
    logic [1:0]        din_size;

    logic [IP_LEN-1:0] calc_len;
    logic              calc_last;
    logic [31:0]       calc_next_addr;
    logic [IP_LEN:0]   calc_next_rem;

    assign din_addr  = adr_aw_din[ADR_ADDR_LSB +: ADR_ADDR_W];
    assign din_len   = adr_aw_din[ADR_LEN_LSB +: IP_LEN];
    assign din_burst = adr_aw_din[BURST_LSB +: 2];
    assign din_size  = adr_aw_din[SIZE_LSB +: 2];

    rpc2_ctrl_page_chunk_calc #(
        .IP_LEN          (IP_LEN),
        .C_BOUNDARY_BITS (C_BOUNDARY_BITS),
        .C_SPLIT_EN      (C_SPLIT_EN)
    ) u_chunk_calc (
        .cur_addr     (cur_addr),
        .rem          (rem),
        .ip_data_size (ds_q),
        .burst        (burst_q),
        .len          (calc_len),
        .last         (calc_last),
        .next_addr    (calc_next_addr),
        .next_rem     (calc_next_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request port is only open in IDLE, so the last handshake of a
    // request always costs one bubble cycle before the next accept.
    always_comb begin
        state_next   = state;
        adr_aw_ready = 1'b0;
        accept       = 1'b0;
        advance      = 1'b0;
        case (state)
            ST_IDLE: begin
                adr_aw_ready = 1'b1;
                if (adr_aw_valid) begin
                    accept     = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cmd_ready) begin
                    advance = 1'b1;
                    if (calc_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // rem holds ip_len+1 units, so it needs one bit more than ip_len.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr <= '0;
            rem      <= '0;
            burst_q  <= '0;
            size_q   <= '0;
            block_q  <= 1'b0;
            ds_q     <= '0;
        end else if (accept) begin
            cur_addr <= din_addr;
            rem      <= {1'b0, din_len} + {{IP_LEN{1'b0}}, 1'b1};
            burst_q  <= din_burst;
            size_q   <= din_size;
            block_q  <= adr_aw_block;
            ds_q     <= ip_data_size;
        end else if (advance) begin
            cur_addr <= calc_next_addr;
            rem      <= calc_next_rem;
        end
    end

    // Command fields come only from registers and are forced to zero outside
    // BUSY, so nothing stale is visible while idle.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_burst = '0;
        cmd_size  = '0;
        cmd_block = 1'b0;
        cmd_last  = 1'b0;
        if (state == ST_BUSY) begin
            cmd_valid = 1'b1;
            cmd_addr  = cur_addr;
            cmd_len   = calc_len;
            cmd_burst = burst_q;
            cmd_size  = size_q;
            cmd_block = block_q;
            cmd_last  = calc_last;
        end
    end

endmodule
